// File: rtl/manta_bus_arbiter.sv
// manta_bus_arbiter
//
// Shares one debug-core register bus between the host UART bridge and an
// on-FPGA local requester. Host requests are single-cycle pulses that are
// buffered in a one-entry holding register. Local requests use a
// valid/ready handshake. A granted request is registered onto the bus.
// An owner-tag pipeline follows each request through the fixed-latency core
// chain, so that each response is steered back to the requester that issued
// it.
//
// Build option:
//   ARB_HOST_PRIORITY_EN - when defined, a pending host request always wins
//                          the bus. When undefined, ties alternate round-robin.
//
// Local handshake: the local side holds loc_valid_i and its request fields
// stable until it sees loc_ready_o. A transfer happens in every cycle where
// loc_valid_i && loc_ready_o. loc_ready_o is combinational and never rises
// without loc_valid_i.

module manta_bus_arbiter #(
   // cycles from bus_valid_o to the matching bus_valid_i; must be >= 1
   parameter int CORE_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_in,

   // host bridge request (no backpressure) and response
   input  logic [15:0] host_addr_i,
   input  logic [15:0] host_data_i,
   input  logic        host_rw_i,
   input  logic        host_valid_i,
   output logic [15:0] host_data_o,
   output logic        host_rw_o,
   output logic        host_valid_o,
   output logic        host_overflow_o,

   // local requester request (valid/ready) and response
   input  logic [15:0] loc_addr_i,
   input  logic [15:0] loc_data_i,
   input  logic        loc_rw_i,
   input  logic        loc_valid_i,
   output logic        loc_ready_o,
   output logic [15:0] loc_data_o,
   output logic        loc_rw_o,
   output logic        loc_valid_o,

   // core chain request (registered) and response
   output logic [15:0] bus_addr_o,
   output logic [15:0] bus_data_o,
   output logic        bus_rw_o,
   output logic        bus_valid_o,
   input  logic [15:0] bus_data_i,
   input  logic        bus_rw_i,
   input  logic        bus_valid_i
);

   // ------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------

   // one-entry host holding buffer
   logic [15:0] host_addr_q;
   logic [15:0] host_data_q;
   logic        host_rw_q;
   logic        host_pend_q;

   // arbitration result for the current cycle
   logic        host_win;
   logic        loc_win;

   // host buffer control
   logic        host_drop;
   logic        host_load;

   // next bus request
   logic        bus_valid_d;
   logic [15:0] bus_addr_d;
   logic [15:0] bus_data_d;
   logic        bus_rw_d;

   // Owner tags. Stage 0 moves together with the registered bus request.
   // Stage k lines up with a core response that arrives k cycles after
   // bus_valid_o. The tail, at index CORE_LATENCY, is therefore aligned
   // with bus_valid_i. Owner bit: 1 = host, 0 = local.
   logic [CORE_LATENCY:0] tag_valid_q;
   logic [CORE_LATENCY:0] tag_owner_q;

   // response steering
   logic        resp_hit;
   logic        resp_host;
   logic        resp_loc;

`ifndef ARB_HOST_PRIORITY_EN
   typedef enum logic {
      OWNER_LOCAL = 1'b0,
      OWNER_HOST  = 1'b1
   } owner_e;

   // The requester granted most recently. It loses the next tie.
   owner_e last_grant_q;
`endif

   // ------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------

   // pick at most one winner between the host buffer and the local request
   always_comb begin
      host_win = 1'b0;
      loc_win  = 1'b0;
`ifdef ARB_HOST_PRIORITY_EN
      if (host_pend_q) begin
         host_win = 1'b1;
      end else if (loc_valid_i) begin
         loc_win = 1'b1;
      end
`else
      if (host_pend_q && loc_valid_i) begin
         if (last_grant_q == OWNER_LOCAL) begin
            host_win = 1'b1;
         end else begin
            loc_win = 1'b1;
         end
      end else if (host_pend_q) begin
         host_win = 1'b1;
      end else if (loc_valid_i) begin
         loc_win = 1'b1;
      end
`endif
   end

   // Gating with reset stops the local side from seeing an accept that the
   // reset would throw away.
   assign loc_ready_o = loc_win && !rst_in;

`ifndef ARB_HOST_PRIORITY_EN
   // remember who was granted last; after reset the host wins the first tie
   always_ff @(posedge clk) begin
      if (rst_in) begin
         last_grant_q <= OWNER_LOCAL;
      end else if (host_win) begin
         last_grant_q <= OWNER_HOST;
      end else if (loc_win) begin
         last_grant_q <= OWNER_LOCAL;
      end
   end
`endif

   // ------------------------------------------------------------------
   // Host holding buffer and overflow
   // ------------------------------------------------------------------

   // A new host pulse is lost only when the buffer is still occupied after
   // this cycle. A pulse that arrives in the same cycle the buffer drains
   // simply refills it.
   assign host_drop = host_valid_i && host_pend_q && !host_win;
   assign host_load = host_valid_i && !host_drop;

   // load the buffer on an accepted host pulse; free it when the host wins
   always_ff @(posedge clk) begin
      if (rst_in) begin
         host_addr_q <= '0;
         host_data_q <= '0;
         host_rw_q   <= 1'b0;
         host_pend_q <= 1'b0;
      end else if (host_load) begin
         host_addr_q <= host_addr_i;
         host_data_q <= host_data_i;
         host_rw_q   <= host_rw_i;
         host_pend_q <= 1'b1;
      end else if (host_win) begin
         host_pend_q <= 1'b0;
      end
   end

   // sticky flag: a host request was dropped since the last reset
   always_ff @(posedge clk) begin
      if (rst_in) begin
         host_overflow_o <= 1'b0;
      end else if (host_drop) begin
         host_overflow_o <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Bus request
   // ------------------------------------------------------------------

   // mux the winner onto the bus; an idle bus carries all zeros
   always_comb begin
      bus_valid_d = 1'b0;
      bus_addr_d  = '0;
      bus_data_d  = '0;
      bus_rw_d    = 1'b0;
      if (host_win) begin
         bus_valid_d = 1'b1;
         bus_addr_d  = host_addr_q;
         bus_data_d  = host_data_q;
         bus_rw_d    = host_rw_q;
      end else if (loc_win) begin
         bus_valid_d = 1'b1;
         bus_addr_d  = loc_addr_i;
         bus_data_d  = loc_data_i;
         bus_rw_d    = loc_rw_i;
      end
   end

   // register the granted request onto the core chain for one cycle
   always_ff @(posedge clk) begin
      if (rst_in) begin
         bus_valid_o <= 1'b0;
         bus_addr_o  <= '0;
         bus_data_o  <= '0;
         bus_rw_o    <= 1'b0;
      end else begin
         bus_valid_o <= bus_valid_d;
         bus_addr_o  <= bus_addr_d;
         bus_data_o  <= bus_data_d;
         bus_rw_o    <= bus_rw_d;
      end
   end

   // ------------------------------------------------------------------
   // Owner-tag pipeline
   // ------------------------------------------------------------------

   // shift the tags every cycle; reset clears every in-flight tag
   always_ff @(posedge clk) begin
      if (rst_in) begin
         tag_valid_q <= '0;
         tag_owner_q <= '0;
      end else begin
         tag_valid_q <= {tag_valid_q[CORE_LATENCY-1:0], bus_valid_d};
         tag_owner_q <= {tag_owner_q[CORE_LATENCY-1:0], host_win};
      end
   end

   // A response without a matching live tag is stale, for example because
   // reset cleared the tags. It is ignored.
   assign resp_hit  = bus_valid_i && tag_valid_q[CORE_LATENCY];
   assign resp_host = resp_hit && tag_owner_q[CORE_LATENCY];
   assign resp_loc  = resp_hit && !tag_owner_q[CORE_LATENCY];

   // ------------------------------------------------------------------
   // Response routing
   // ------------------------------------------------------------------

   // forward a response to the host side; hold zeros otherwise
   always_ff @(posedge clk) begin
      if (rst_in) begin
         host_valid_o <= 1'b0;
         host_data_o  <= '0;
         host_rw_o    <= 1'b0;
      end else begin
         host_valid_o <= resp_host;
         host_data_o  <= resp_host ? bus_data_i : 16'h0000;
         host_rw_o    <= resp_host && bus_rw_i;
      end
   end

   // forward a response to the local side; hold zeros otherwise
   always_ff @(posedge clk) begin
      if (rst_in) begin
         loc_valid_o <= 1'b0;
         loc_data_o  <= '0;
         loc_rw_o    <= 1'b0;
      end else begin
         loc_valid_o <= resp_loc;
         loc_data_o  <= resp_loc ? bus_data_i : 16'h0000;
         loc_rw_o    <= resp_loc && bus_rw_i;
      end
   end

endmodule

// File: tb/tb_manta_bus_arbiter.sv
// Bench for manta_bus_arbiter. It uses two instances:
//   dut_a: CORE_LATENCY = 1
//   dut_b: CORE_LATENCY = 3
// Both share the request inputs. Each instance has its own echo-core model,
// built from a delay queue plus a small register file.
module tb_manta_bus_arbiter;

   localparam int LAT_A = 1;
   localparam int LAT_B = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_in;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- shared request inputs ----------------
   logic [15:0] host_addr_i, host_data_i, loc_addr_i, loc_data_i;
   logic        host_rw_i, host_valid_i, loc_rw_i, loc_valid_i;

   // ---------------- dut_a signals ----------------
   logic [15:0] a_host_data_o, a_loc_data_o, a_bus_addr_o, a_bus_data_o, a_bus_data_i;
   logic        a_host_rw_o, a_host_valid_o, a_host_overflow_o, a_loc_ready_o;
   logic        a_loc_rw_o, a_loc_valid_o, a_bus_rw_o, a_bus_valid_o;
   logic        a_bus_rw_i, a_bus_valid_i;

   // ---------------- dut_b signals ----------------
   logic [15:0] b_host_data_o, b_loc_data_o, b_bus_addr_o, b_bus_data_o, b_bus_data_i;
   logic        b_host_rw_o, b_host_valid_o, b_host_overflow_o, b_loc_ready_o;
   logic        b_loc_rw_o, b_loc_valid_o, b_bus_rw_o, b_bus_valid_o;
   logic        b_bus_rw_i, b_bus_valid_i;

   manta_bus_arbiter #(.CORE_LATENCY(LAT_A)) dut_a (
      .clk(clk), .rst_in(rst_in),
      .host_addr_i(host_addr_i), .host_data_i(host_data_i),
      .host_rw_i(host_rw_i), .host_valid_i(host_valid_i),
      .host_data_o(a_host_data_o), .host_rw_o(a_host_rw_o),
      .host_valid_o(a_host_valid_o), .host_overflow_o(a_host_overflow_o),
      .loc_addr_i(loc_addr_i), .loc_data_i(loc_data_i),
      .loc_rw_i(loc_rw_i), .loc_valid_i(loc_valid_i), .loc_ready_o(a_loc_ready_o),
      .loc_data_o(a_loc_data_o), .loc_rw_o(a_loc_rw_o), .loc_valid_o(a_loc_valid_o),
      .bus_addr_o(a_bus_addr_o), .bus_data_o(a_bus_data_o),
      .bus_rw_o(a_bus_rw_o), .bus_valid_o(a_bus_valid_o),
      .bus_data_i(a_bus_data_i), .bus_rw_i(a_bus_rw_i), .bus_valid_i(a_bus_valid_i)
   );

   manta_bus_arbiter #(.CORE_LATENCY(LAT_B)) dut_b (
      .clk(clk), .rst_in(rst_in),
      .host_addr_i(host_addr_i), .host_data_i(host_data_i),
      .host_rw_i(host_rw_i), .host_valid_i(host_valid_i),
      .host_data_o(b_host_data_o), .host_rw_o(b_host_rw_o),
      .host_valid_o(b_host_valid_o), .host_overflow_o(b_host_overflow_o),
      .loc_addr_i(loc_addr_i), .loc_data_i(loc_data_i),
      .loc_rw_i(loc_rw_i), .loc_valid_i(loc_valid_i), .loc_ready_o(b_loc_ready_o),
      .loc_data_o(b_loc_data_o), .loc_rw_o(b_loc_rw_o), .loc_valid_o(b_loc_valid_o),
      .bus_addr_o(b_bus_addr_o), .bus_data_o(b_bus_data_o),
      .bus_rw_o(b_bus_rw_o), .bus_valid_o(b_bus_valid_o),
      .bus_data_i(b_bus_data_i), .bus_rw_i(b_bus_rw_i), .bus_valid_i(b_bus_valid_i)
   );

   // ---------------- echo-core model ----------------
   typedef struct packed {
      logic        v;
      logic [15:0] addr;
      logic [15:0] data;
      logic        rw;
   } breq_t;

   breq_t       qa[$];
   breq_t       qb[$];
   logic [15:0] mem [16];

   function automatic breq_t core_resp(input breq_t r);
      breq_t s;
      s = '0;
      if (r.v) begin
         s.v  = 1'b1;
         s.rw = r.rw;
         if (r.rw) begin
            s.data = r.data;
            mem[r.addr[3:0]] = r.data;
         end else begin
            s.data = mem[r.addr[3:0]];
         end
      end
      return s;
   endfunction

   // Advance one clock. Sample both buses just after the edge, then drive
   // each core response that was queued LAT cycles earlier.
   task automatic tick();
      breq_t ra, rb;
      @(posedge clk);
      #1;
      qa.push_back('{a_bus_valid_o, a_bus_addr_o, a_bus_data_o, a_bus_rw_o});
      qb.push_back('{b_bus_valid_o, b_bus_addr_o, b_bus_data_o, b_bus_rw_o});
      ra = core_resp(qa.pop_front());
      rb = core_resp(qb.pop_front());
      a_bus_valid_i = ra.v;
      a_bus_data_i  = ra.data;
      a_bus_rw_i    = ra.rw;
      b_bus_valid_i = rb.v;
      b_bus_data_i  = rb.data;
      b_bus_rw_i    = rb.rw;
   endtask

   // ---------------- scoreboard / checks ----------------
   int checks = 0;
   int errors = 0;

   task automatic chk16(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic chk1(input string name, input int idx, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
      end
   endtask

   typedef struct {
      logic rdy; logic bv; logic [15:0] ba; logic [15:0] bd; logic brw;
      logic hv; logic [15:0] hd; logic hrw;
      logic lv; logic [15:0] ld; logic lrw; logic ovf;
   } obs_t;

   function automatic obs_t get_obs(input int sel);
      obs_t o;
      if (sel == 0) begin
         o = '{a_loc_ready_o, a_bus_valid_o, a_bus_addr_o, a_bus_data_o, a_bus_rw_o,
               a_host_valid_o, a_host_data_o, a_host_rw_o,
               a_loc_valid_o, a_loc_data_o, a_loc_rw_o, a_host_overflow_o};
      end else begin
         o = '{b_loc_ready_o, b_bus_valid_o, b_bus_addr_o, b_bus_data_o, b_bus_rw_o,
               b_host_valid_o, b_host_data_o, b_host_rw_o,
               b_loc_valid_o, b_loc_data_o, b_loc_rw_o, b_host_overflow_o};
      end
      return o;
   endfunction

   // One vector holds the inputs for one cycle, the expected loc_ready in
   // that cycle, and the expected registered outputs after its clock edge.
   typedef struct {
      logic hv; logic [15:0] ha; logic [15:0] hd; logic hrw;
      logic lv; logic [15:0] la; logic [15:0] ld; logic lrw;
      obs_t e;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic hv, input logic [15:0] ha, input logic [15:0] hd, input logic hrw,
      input logic lv, input logic [15:0] la, input logic [15:0] ld, input logic lrw,
      input logic rdy,
      input logic bv, input logic [15:0] ba, input logic [15:0] bd, input logic brw,
      input logic hov, input logic [15:0] hod, input logic horw,
      input logic lov, input logic [15:0] lod, input logic lorw,
      input logic ovf);
      vec_t v;
      v.hv = hv; v.ha = ha; v.hd = hd; v.hrw = hrw;
      v.lv = lv; v.la = la; v.ld = ld; v.lrw = lrw;
      v.e = '{rdy, bv, ba, bd, brw, hov, hod, horw, lov, lod, lorw, ovf};
      return v;
   endfunction

   task automatic drive_idle();
      host_valid_i = 1'b0; host_addr_i = '0; host_data_i = '0; host_rw_i = 1'b0;
      loc_valid_i  = 1'b0; loc_addr_i  = '0; loc_data_i  = '0; loc_rw_i  = 1'b0;
   endtask

   task automatic run_vecs(input string tag, input int sel);
      obs_t o;
      foreach (vecs[i]) begin
         host_valid_i = vecs[i].hv; host_addr_i = vecs[i].ha;
         host_data_i  = vecs[i].hd; host_rw_i   = vecs[i].hrw;
         loc_valid_i  = vecs[i].lv; loc_addr_i  = vecs[i].la;
         loc_data_i   = vecs[i].ld; loc_rw_i    = vecs[i].lrw;
         #1;
         o = get_obs(sel);
         chk1({tag, "_loc_ready"}, i, o.rdy, vecs[i].e.rdy);
         tick();
         o = get_obs(sel);
         chk1 ({tag, "_bus_valid"},  i, o.bv,  vecs[i].e.bv);
         chk16({tag, "_bus_addr"},   i, o.ba,  vecs[i].e.ba);
         chk16({tag, "_bus_data"},   i, o.bd,  vecs[i].e.bd);
         chk1 ({tag, "_bus_rw"},     i, o.brw, vecs[i].e.brw);
         chk1 ({tag, "_host_valid"}, i, o.hv,  vecs[i].e.hv);
         chk16({tag, "_host_data"},  i, o.hd,  vecs[i].e.hd);
         chk1 ({tag, "_host_rw"},    i, o.hrw, vecs[i].e.hrw);
         chk1 ({tag, "_loc_valid"},  i, o.lv,  vecs[i].e.lv);
         chk16({tag, "_loc_data"},   i, o.ld,  vecs[i].e.ld);
         chk1 ({tag, "_loc_rw"},     i, o.lrw, vecs[i].e.lrw);
         chk1 ({tag, "_overflow"},   i, o.ovf, vecs[i].e.ovf);
      end
      drive_idle();
   endtask

   task automatic chk_all_zero(input string tag, input int idx, input int sel);
      obs_t o;
      o = get_obs(sel);
      chk1 ({tag, "_bus_valid"},  idx, o.bv,  1'b0);
      chk16({tag, "_bus_addr"},   idx, o.ba,  16'h0000);
      chk1 ({tag, "_host_valid"}, idx, o.hv,  1'b0);
      chk16({tag, "_host_data"},  idx, o.hd,  16'h0000);
      chk1 ({tag, "_loc_valid"},  idx, o.lv,  1'b0);
      chk16({tag, "_loc_data"},   idx, o.ld,  16'h0000);
      chk1 ({tag, "_overflow"},   idx, o.ovf, 1'b0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);
      mem[3] = 16'hBEEF;
      drive_idle();
      a_bus_valid_i = 1'b0; a_bus_data_i = '0; a_bus_rw_i = 1'b0;
      b_bus_valid_i = 1'b0; b_bus_data_i = '0; b_bus_rw_i = 1'b0;
      for (int i = 0; i < LAT_A; i++) qa.push_back('0);
      for (int i = 0; i < LAT_B; i++) qb.push_back('0);

      // reset state; local request held high must not be accepted in reset
      rst_in = 1'b1;
      loc_valid_i = 1'b1;
      repeat (3) tick();
      chk1("rst_loc_ready", 0, a_loc_ready_o, 1'b0);
      chk_all_zero("rst_a", 0, 0);
      chk_all_zero("rst_b", 0, 1);
      loc_valid_i = 1'b0;
      rst_in = 1'b0;

      // ---- CORE_LATENCY = 1 table ----
      vecs.delete();
      // tie after reset: host first, then alternate; host reload while granted
      vecs.push_back(mk(1,'h5,0,0, 0,0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,0, 0));
      vecs.push_back(mk(1,'h7,0,0, 1,'h6,0,0, 0, 1,'h5,0,0, 0,0,0, 0,0,0, 0));
      vecs.push_back(mk(0,0,0,0, 1,'h6,0,0, 1, 1,'h6,0,0, 0,0,0, 0,0,0, 0));
      vecs.push_back(mk(0,0,0,0, 1,'h8,0,0, 0, 1,'h7,0,0, 1,'h1005,0, 0,0,0, 0));
      vecs.push_back(mk(1,'h9,0,0, 1,'h8,0,0, 1, 1,'h8,0,0, 0,0,0, 1,'h1006,0, 0));
      vecs.push_back(mk(0,0,0,0, 1,'hA,0,0, 0, 1,'h9,0,0, 1,'h1007,0, 0,0,0, 0));
      vecs.push_back(mk(0,0,0,0, 1,'hA,0,0, 1, 1,'hA,0,0, 0,0,0, 1,'h1008,0, 0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0, 0,0,0,0, 1,'h1009,0, 0,0,0, 0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0, 0,0,0,0, 0,0,0, 1,'h100A,0, 0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,0, 0));
      // local read alone, core returns 0xBEEF
      vecs.push_back(mk(0,0,0,0, 1,'h3,0,0, 1, 1,'h3,0,0, 0,0,0, 0,0,0, 0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,0, 0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0, 0,0,0,0, 0,0,0, 1,'hBEEF,0, 0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,0, 0));
      // host write alone, echo returns with rw = 1
      vecs.push_back(mk(1,'h0,'h1,1, 0,0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,0, 0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0, 1,'h0,'h1,1, 0,0,0, 0,0,0, 0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,0, 0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0, 0,0,0,0, 1,'h1,1, 0,0,0, 0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,0, 0));
      // overflow: second host pulse while local wins the tie
      vecs.push_back(mk(1,'hB,0,0, 0,0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,0, 0));
      vecs.push_back(mk(1,'hD,0,0, 1,'hE,0,0, 1, 1,'hE,0,0, 0,0,0, 0,0,0, 1));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0, 1,'hB,0,0, 0,0,0, 0,0,0, 1));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0, 0,0,0,0, 0,0,0, 1,'h100E,0, 1));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0, 0,0,0,0, 1,'h100B,0, 0,0,0, 1));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,0, 1));
      run_vecs("l1", 0);

      // ---- reset while a request is in flight ----
      loc_valid_i = 1'b1; loc_addr_i = 16'h0004;
      #1;
      chk1("rif_loc_ready", 0, a_loc_ready_o, 1'b1);
      tick();
      chk1("rif_bus_valid", 0, a_bus_valid_o, 1'b1);
      loc_valid_i = 1'b0; loc_addr_i = '0;
      host_valid_i = 1'b1; host_addr_i = 16'h0002;
      tick();
      host_valid_i = 1'b0; host_addr_i = '0;
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk_all_zero("rif_a", k, 0);
         chk_all_zero("rif_b", k, 1);
         tick();
      end

      // ---- CORE_LATENCY = 3, back-to-back host and local reads ----
      vecs.delete();
      vecs.push_back(mk(1,'h1,0,0, 1,'h2,0,0, 1, 1,'h2,0,0, 0,0,0, 0,0,0, 0));
      vecs.push_back(mk(0,0,0,0, 1,'h4,0,0, 0, 1,'h1,0,0, 0,0,0, 0,0,0, 0));
      vecs.push_back(mk(0,0,0,0, 1,'h4,0,0, 1, 1,'h4,0,0, 0,0,0, 0,0,0, 0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,0, 0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0, 0,0,0,0, 0,0,0, 1,'h1002,0, 0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0, 0,0,0,0, 1,'h1001,0, 0,0,0, 0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0, 0,0,0,0, 0,0,0, 1,'h1004,0, 0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,0, 0));
      run_vecs("l3", 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
